switch_conditioner: RTL and testbench

- Input-conditioning stage directly upstream of the stopwatch processor's switch PIO inputs: mode0, mode1, pause and reset switches.
- Per channel: synchronises the raw board switch into clk, debounces it, and presents a clean level plus single-cycle rise and fall strobes.
- The clean levels drive the processor's switch PIO exports; the strobes are available for edge-triggered logic.

---
 rtl/switch_conditioner_pkg.sv | 24 ++
 rtl/switch_conditioner_debounce_channel.sv | 150 +++++++++++++++
 rtl/switch_conditioner.sv | 61 ++++++
 tb/tb_switch_conditioner.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// switch_conditioner_pkg
// Shared types and constants for the stopwatch switch conditioner.
//   db_state_t        : per-channel debounce FSM state encoding
//   CH_*              : bit positions of each switch within the channel vector
//   DB_CYCLES_DEFAULT : default debounce length (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package switch_conditioner_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        LOW_PEND  = 2'd1,
        HIGH      = 2'd2,
        HIGH_PEND = 2'd3
    } db_state_t;

    localparam int CH_MODE0 = 0;
    localparam int CH_MODE1 = 1;
    localparam int CH_PAUSE = 2;
    localparam int CH_RESET = 3;

    localparam int DB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/switch_conditioner_debounce_channel.sv
// -----------------------------------------------------------------------------
// switch_conditioner_debounce_channel
// One switch channel: synchroniser chain, debounce counter and 4-state FSM.
// Ports:
//   i_clk       : system clock
//   i_reset     : synchronous active-high reset
//   i_raw       : asynchronous raw switch level
//   o_clean     : debounced level (registered)
//   o_rise      : one-cycle strobe on clean 0->1 (registered)
//   o_fall      : one-cycle strobe on clean 1->0 (registered)
//   o_rise_nxt  : value o_rise takes at the next edge (feeds the top-level OR)
//   o_fall_nxt  : value o_fall takes at the next edge (feeds the top-level OR)
// -----------------------------------------------------------------------------
module switch_conditioner_debounce_channel
    import switch_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
)(
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_clean,
    output logic o_rise,
    output logic o_fall,
    output logic o_rise_nxt,
    output logic o_fall_nxt
);

    localparam int              CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // The count that, when seen with a still-stable input, completes qualification.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    db_state_t              r_state;
    db_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_clean_nxt;
    logic                   w_rise_nxt;
    logic                   w_fall_nxt;
    logic                   r_clean;
    logic                   r_rise;
    logic                   r_fall;

    // Synchroniser chain: raw enters at bit 0, the top bit is the qualified sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // FSM state, counter and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= LOW;
            r_cnt   <= CNT_ZERO;
            r_clean <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_clean <= w_clean_nxt;
            r_rise  <= w_rise_nxt;
            r_fall  <= w_fall_nxt;
        end
    end

    // Next-state and strobe decode; any disagreement while pending restarts from the settled state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        case (r_state)
            LOW: begin
                if (w_s) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = HIGH;
                        w_cnt_nxt   = CNT_ZERO;
                        w_rise_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = LOW_PEND;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            LOW_PEND: begin
                if (!w_s) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            HIGH: begin
                if (!w_s) begin
                    if (DB_CYCLES == 1) begin
                        w_state_nxt = LOW;
                        w_cnt_nxt   = CNT_ZERO;
                        w_fall_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = HIGH_PEND;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end else begin
                    w_cnt_nxt = CNT_ZERO;
                end
            end
            HIGH_PEND: begin
                if (w_s) begin
                    w_state_nxt = HIGH;
                    w_cnt_nxt   = CNT_ZERO;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = CNT_ZERO;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = LOW;
                w_cnt_nxt   = CNT_ZERO;
            end
        endcase
        w_clean_nxt = (w_state_nxt == HIGH) || (w_state_nxt == HIGH_PEND);
    end

    assign o_clean    = r_clean;
    assign o_rise     = r_rise;
    assign o_fall     = r_fall;
    assign o_rise_nxt = w_rise_nxt;
    assign o_fall_nxt = w_fall_nxt;

endmodule

// File: rtl/switch_conditioner.sv
// -----------------------------------------------------------------------------
// switch_conditioner
// Synchronises and debounces the stopwatch switches (mode0, mode1, pause,
// reset) and provides clean levels plus single-cycle edge strobes.
// Ports:
//   clk          : system clock (same as the processor)
//   reset        : synchronous active-high reset
//   raw_i        : raw asynchronous switch levels from the board
//   clean_o      : debounced synchronised levels
//   rise_o       : one-cycle strobe per channel on clean 0->1
//   fall_o       : one-cycle strobe per channel on clean 1->0
//   any_change_o : OR of all strobes, aligned with them
// -----------------------------------------------------------------------------
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = DB_CYCLES_DEFAULT
)(
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] raw_i,
    output logic [N_CH-1:0] clean_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o,
    output logic            any_change_o
);

    logic [N_CH-1:0] w_rise_nxt;
    logic [N_CH-1:0] w_fall_nxt;
    logic            r_any;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        switch_conditioner_debounce_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES)
        ) u_ch (
            .i_clk      (clk),
            .i_reset    (reset),
            .i_raw      (raw_i[g]),
            .o_clean    (clean_o[g]),
            .o_rise     (rise_o[g]),
            .o_fall     (fall_o[g]),
            .o_rise_nxt (w_rise_nxt[g]),
            .o_fall_nxt (w_fall_nxt[g])
        );
    end

    // Combined change flag, built from next-cycle strobes so it lands with them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_any <= 1'b0;
        end else begin
            r_any <= |(w_rise_nxt | w_fall_nxt);
        end
    end

    assign any_change_o = r_any;

endmodule

// File: tb/tb_switch_conditioner.sv
// Directed bench for switch_conditioner with SYNC_STAGES=2, DB_CYCLES=4:
// a change presented before edge 1 shows on clean_o after edge 6.
module tb_switch_conditioner;

    localparam int N_CH        = 4;
    localparam int SYNC_STAGES = 2;
    localparam int DB_CYCLES   = 4;
    localparam int LAT         = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raw_i;
    logic [3:0] clean_o;
    logic [3:0] rise_o;
    logic [3:0] fall_o;
    logic       any_change_o;

    int n_vec = 0;
    int n_err = 0;

    switch_conditioner #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .DB_CYCLES   (DB_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .raw_i        (raw_i),
        .clean_o      (clean_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o),
        .any_change_o (any_change_o)
    );

    always #5 clk = ~clk;

    // One active edge, then settle at the falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        raw_i = 4'b0000;
        step();
        step();
        n_vec++;
        if ({clean_o, rise_o, fall_o, any_change_o} !== 13'd0) begin
            n_err++;
            $display("FAIL reset: clean=%b rise=%b fall=%b any=%b, required all zero",
                     clean_o, rise_o, fall_o, any_change_o);
        end
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== 13'd0) begin
                n_err++;
                $display("FAIL idle k=%0d: clean=%b rise=%b fall=%b any=%b, required all zero",
                         k, clean_o, rise_o, fall_o, any_change_o);
            end
        end
    endtask

    task automatic test_clean_step();
        logic [3:0] e_clean, e_rise;
        logic       e_any;
        raw_i = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            step();
            e_clean = (k >= LAT) ? 4'b0001 : 4'b0000;
            e_rise  = (k == LAT) ? 4'b0001 : 4'b0000;
            e_any   = (k == LAT);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, e_rise, 4'b0000, e_any}) begin
                n_err++;
                $display("FAIL clean_step k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=0000 any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_rise, e_any);
            end
        end
    endtask

    // Ch2: high for 3 samples, low for 1, then high; qualification restarts at k=5.
    task automatic test_bounce();
        logic [3:0] e_clean, e_rise;
        logic       e_any;
        for (int k = 1; k <= 13; k++) begin
            raw_i = (k == 4) ? 4'b0001 : 4'b0101;
            step();
            e_clean = (k >= 10) ? 4'b0101 : 4'b0001;
            e_rise  = (k == 10) ? 4'b0100 : 4'b0000;
            e_any   = (k == 10);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, e_rise, 4'b0000, e_any}) begin
                n_err++;
                $display("FAIL bounce k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=0000 any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_rise, e_any);
            end
        end
    endtask

    // Longest rejectable glitch on ch1: 3 samples high, then low.
    task automatic test_glitch();
        for (int k = 1; k <= 10; k++) begin
            raw_i = (k <= DB_CYCLES - 1) ? 4'b0111 : 4'b0101;
            step();
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {4'b0101, 4'b0000, 4'b0000, 1'b0}) begin
                n_err++;
                $display("FAIL glitch k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=0101 rise=0000 fall=0000 any=0",
                         k, clean_o, rise_o, fall_o, any_change_o);
            end
        end
    endtask

    task automatic test_release();
        logic [3:0] e_clean, e_fall;
        logic       e_any;
        raw_i = 4'b0111;
        for (int k = 1; k <= 8; k++) begin
            step();
        end
        n_vec++;
        if (clean_o !== 4'b0111) begin
            n_err++;
            $display("FAIL release_settle: clean=%b, required 0111", clean_o);
        end
        raw_i = 4'b0101;
        for (int k = 1; k <= 8; k++) begin
            step();
            e_clean = (k >= LAT) ? 4'b0101 : 4'b0111;
            e_fall  = (k == LAT) ? 4'b0010 : 4'b0000;
            e_any   = (k == LAT);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, 4'b0000, e_fall, e_any}) begin
                n_err++;
                $display("FAIL release k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=0000 fall=%b any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_fall, e_any);
            end
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [3:0] e_clean, e_rise;
        logic       e_any;
        reset = 1'b1;
        raw_i = 4'b0000;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
        end
        raw_i = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            step();
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== 13'd0) begin
                n_err++;
                $display("FAIL pend_pre k=%0d: clean=%b rise=%b fall=%b any=%b, required all zero",
                         k, clean_o, rise_o, fall_o, any_change_o);
            end
        end
        reset = 1'b1;
        step();
        n_vec++;
        if ({clean_o, rise_o, fall_o, any_change_o} !== 13'd0) begin
            n_err++;
            $display("FAIL pend_in_reset: clean=%b rise=%b fall=%b any=%b, required all zero",
                     clean_o, rise_o, fall_o, any_change_o);
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e_clean = (k >= LAT) ? 4'b1000 : 4'b0000;
            e_rise  = (k == LAT) ? 4'b1000 : 4'b0000;
            e_any   = (k == LAT);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, e_rise, 4'b0000, e_any}) begin
                n_err++;
                $display("FAIL pend_post k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=0000 any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_rise, e_any);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] e_clean, e_rise;
        logic       e_any;
        reset = 1'b1;
        raw_i = 4'b0000;
        step();
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
        end
        raw_i = 4'b1111;
        for (int k = 1; k <= 9; k++) begin
            step();
            e_clean = (k >= LAT) ? 4'b1111 : 4'b0000;
            e_rise  = (k == LAT) ? 4'b1111 : 4'b0000;
            e_any   = (k == LAT);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, e_rise, 4'b0000, e_any}) begin
                n_err++;
                $display("FAIL simultaneous k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=0000 any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_rise, e_any);
            end
        end
    endtask

    task automatic test_powerup_high();
        logic [3:0] e_clean, e_rise;
        logic       e_any;
        reset = 1'b1;
        raw_i = 4'b0101;
        for (int k = 1; k <= 3; k++) begin
            step();
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== 13'd0) begin
                n_err++;
                $display("FAIL powerup_reset k=%0d: clean=%b rise=%b fall=%b any=%b, required all zero",
                         k, clean_o, rise_o, fall_o, any_change_o);
            end
        end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            e_clean = (k >= LAT) ? 4'b0101 : 4'b0000;
            e_rise  = (k == LAT) ? 4'b0101 : 4'b0000;
            e_any   = (k == LAT);
            n_vec++;
            if ({clean_o, rise_o, fall_o, any_change_o} !== {e_clean, e_rise, 4'b0000, e_any}) begin
                n_err++;
                $display("FAIL powerup k=%0d: clean=%b rise=%b fall=%b any=%b, required clean=%b rise=%b fall=0000 any=%b",
                         k, clean_o, rise_o, fall_o, any_change_o, e_clean, e_rise, e_any);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        raw_i = 4'b0000;
        @(negedge clk);
        test_reset();
        test_clean_step();
        test_bounce();
        test_glitch();
        test_release();
        test_reset_mid_pending();
        test_simultaneous();
        test_powerup_high();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
